cmp_probe_pipe: RTL and testbench

CMP_PROBE_PIPE -- requirements
Module: cmp_probe_pipe

---
 rtl/cmp_probe_pipe.sv | 153 +++++++++++++++
 tb/tb_cmp_probe_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmp_probe_pipe.sv
// rtl/cmp_probe_pipe.sv - pipelined per-channel comparator with hit-count probe
// Probe FSM and probe_data are built only when CMP_PROBE_EN is defined.
module cmp_probe_pipe #(
  parameter int DATA_W  = 96,
  parameter int SLICE_W = 2,
  parameter int NCH     = 4,
  parameter int PIPE    = 2,
  parameter int HIT_THR = 8
) (
  input  logic              clkin_data,
  input  logic              rstn_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        cmp_mode,
  input  logic              arm,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       probe_data
);

  generate
    if (NCH < 1 || NCH > 64) begin : g_bad_nch
      $error("cmp_probe_pipe: NCH must be in 1..64");
    end
    if (NCH * 2 * SLICE_W > DATA_W) begin : g_bad_width
      $error("cmp_probe_pipe: NCH*2*SLICE_W exceeds DATA_W");
    end
    if (PIPE < 1) begin : g_bad_pipe
      $error("cmp_probe_pipe: PIPE must be at least 1");
    end
    if (HIT_THR < 1 || HIT_THR > 24'hFF_FFFF) begin : g_bad_thr
      $error("cmp_probe_pipe: HIT_THR must be in 1..2^24-1");
    end
  endgenerate

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [NCH-1:0]     cmp_res;
  logic [SLICE_W-1:0] op_a;
  logic [SLICE_W-1:0] op_b;
  logic               unused_in;

  assign unused_in = ^in_data;

  always_comb begin
    cmp_res = '0;
    op_a    = '0;
    op_b    = '0;
    for (int i = 0; i < NCH; i++) begin
      op_a = in_data[2*i*SLICE_W +: SLICE_W];
      op_b = in_data[2*i*SLICE_W+SLICE_W +: SLICE_W];
      case (cmp_mode)
        2'b00:   cmp_res[i] = (op_a < op_b);
        2'b01:   cmp_res[i] = (op_a == op_b);
        2'b10:   cmp_res[i] = (op_a > op_b);
        default: cmp_res[i] = |(op_a & op_b);
      endcase
    end
  end

  // Results advance only with their valid, so the last stage holds across bubbles.
  logic [PIPE-1:0] vld_q;
  logic [NCH-1:0]  res_q [PIPE];

  always_ff @(posedge clkin_data or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE; k++) res_q[k] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) res_q[0] <= cmp_res;
      for (int k = 1; k < PIPE; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) res_q[k] <= res_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[PIPE-1];
  assign out_data  = {{(DATA_W-NCH){1'b0}}, res_q[PIPE-1]};

`ifdef CMP_PROBE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_HIT   = 2'b10
  } probe_state_t;

  localparam logic [23:0] THR     = 24'(HIT_THR);
  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;

  probe_state_t state_q, state_d;
  logic [23:0]  cnt_q, cnt_d;
  logic [5:0]   chan_q, chan_d;
  logic [5:0]   low_idx;
  logic         hit;

  assign hit = out_valid & (|res_q[PIPE-1]);

  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (res_q[PIPE-1][i]) low_idx = 6'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    if (arm) begin
      state_d = S_ARMED;
      cnt_d   = '0;
      chan_d  = '0;
    end else if (state_q == S_ARMED && hit) begin
      if (cnt_q == 24'd0) chan_d = low_idx;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_d == THR) state_d = S_HIT;
      end
    end
  end

  always_ff @(posedge clkin_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
    end
  end

  assign probe_data = {state_q, chan_q, cnt_q};
`else
  logic unused_arm;

  assign unused_arm = arm;
  assign probe_data = '0;
`endif

endmodule

// File: tb/tb_cmp_probe_pipe.sv
// tb/tb_cmp_probe_pipe.sv - directed self-checking bench for cmp_probe_pipe
// Probe expectations follow CMP_PROBE_EN; without it probe_data must read 0.
module tb_cmp_probe_pipe;

`ifdef CMP_PROBE_EN
  localparam bit PROBE_ON = 1'b1;
`else
  localparam bit PROBE_ON = 1'b0;
`endif

  localparam logic [79:0] HI = 80'h0123_4567_89AB_CDEF_FEDC;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic [95:0] in_data = '0;
  logic [1:0]  cmp_mode = 2'b00;
  logic        arm = 1'b0;
  logic        out_valid;
  logic [95:0] out_data;
  logic [31:0] probe_data;

  int n_chk = 0;
  int n_pass = 0;

  cmp_probe_pipe dut (
    .clkin_data (clk),
    .rstn_data  (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cmp_mode   (cmp_mode),
    .arm        (arm),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .probe_data (probe_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_chk++;
    if (obs !== exp_v) $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pexp(input logic [31:0] v);
    return v & {32{PROBE_ON}};
  endfunction

  // {valid, mode, data[15:0], expected result[3:0]}
  logic [22:0] tbl [9] = '{
    {1'b1, 2'd0, 16'hAC39, 4'h5},
    {1'b1, 2'd1, 16'hAC39, 4'h8},
    {1'b1, 2'd2, 16'hAC39, 4'h2},
    {1'b1, 2'd3, 16'hFE97, 4'hD},
    {1'b0, 2'd0, 16'h0000, 4'h0},
    {1'b1, 2'd1, 16'hFFFF, 4'hF},
    {1'b0, 2'd1, 16'hFFFF, 4'h0},
    {1'b1, 2'd1, 16'hFFFF, 4'hF},
    {1'b1, 2'd0, 16'h0009, 4'h1}
  };

  initial begin
    logic        v;
    logic [1:0]  m;
    logic [15:0] d;
    logic [3:0]  e;
    logic [3:0]  held;

    #1 rstn = 1'b0;
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_probe", probe_data, 0);

    rstn = 1'b1;
    repeat (4) cyc();

    // A0=1 < B0=2 on channel 0, result two cycles after presentation
    in_valid = 1'b1; cmp_mode = 2'b00; in_data = 96'h9;
    cyc();
    in_valid = 1'b0;
    chk("lat_early", out_valid, 0);
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 96'h1);
    cyc();
    chk("lat_after", out_valid, 0);

    held = 4'h1;
    for (int k = 0; k <= 9; k++) begin
      if (k < 9) begin
        {v, m, d, e} = tbl[k];
        in_valid = v; cmp_mode = m; in_data = {HI, d};
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (k >= 1) begin
        {v, m, d, e} = tbl[k-1];
        if (v) held = e;
        chk($sformatf("tbl%0d_vld", k-1), out_valid, v);
        chk($sformatf("tbl%0d_data", k-1), out_data, {92'b0, held});
      end
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("idle_ignore", probe_data, 0);

    arm = 1'b1; cyc(); arm = 1'b0;
    chk("armed", probe_data, pexp(32'h4000_0000));

    // first hit lowest channel 2 (result 1100), then seven all-channel hits
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; cmp_mode = 2'b01;
      in_data = (j == 0) ? {HI, 16'h0011} : {HI, 16'hFFFF};
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("hit8_probe", probe_data, pexp(32'h8200_0008));
    chk("hit8_data", out_data, 96'hF);

    in_valid = 1'b1; in_data = {HI, 16'hFFFF};
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("hit9_hold", probe_data, pexp(32'h8200_0008));

    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("coinc_hit_vis", out_valid, 1);
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("coinc_arm", probe_data, pexp(32'h4000_0000));

    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; cmp_mode = 2'b01; in_data = {HI, 16'hFFFF};
      cyc();
    end
    cmp_mode = 2'b00; in_data = 96'h0;
    repeat (3) cyc();
    chk("cnt5_probe", probe_data, pexp(32'h4000_0005));
    chk("cnt5_vld", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_probe", probe_data, 0);
    chk("async_vld", out_valid, 0);
    chk("async_data", out_data, 0);

    in_valid = 1'b1; cmp_mode = 2'b00; in_data = 96'h9;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) cyc();
    chk("rel_sync_vld", out_valid, 0);
    repeat (4) cyc();
    chk("rel_vld", out_valid, 1);
    chk("rel_data", out_data, 96'h1);
    chk("rel_probe", probe_data, 0);
    in_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
